// File: rtl/reg_bank_arb_pkg.sv
// Shared state type and default sizes for reg_bank_arbiter.
// The LOCKED state exists only when REG_BANK_ARB_LOCK_EN is defined.
package reg_bank_arb_pkg;
  localparam int N_DEF    = 4;
  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;

`ifdef REG_BANK_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_e;
`endif
endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// Rotating-priority picker: grants the first active request at or after ptr, wrapping.
module rr_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);
  logic [PW-1:0] idx_s;

  // Walk offsets from farthest to nearest so the closest requester overrides.
  always_comb begin
    gnt   = '0;
    idx_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = PW'((int'(ptr) + k) % NREQ);
      gnt   = req[idx_s] ? (NREQ'(1'b1) << idx_s) : gnt;
    end
    valid = |req;
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank with round-robin arbitrated write requesters and a combinational read port.
// Define REG_BANK_ARB_LOCK_EN to add the LOCK input and the LOCKED burst-write state.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int  N    = N_DEF,
  parameter int  NREQ = NREQ_DEF,
  parameter int  NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG),
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*AW-1:0] WADDR,
  input  logic [NREQ*N-1:0] WDATA,
  output logic [NREQ-1:0]   ACK,
  input  logic [AW-1:0]     RADDR,
  output logic [N-1:0]      RDATA,
  output logic              BUSY
`ifdef REG_BANK_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]   LOCK
`endif
);
  localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

  state_e          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    bank_q [NREG];
  logic [N-1:0]    bank_d [NREG];
  logic [NREQ-1:0] elig_s, gnt_s;
  logic [PW-1:0]   arb_ptr_s, win_s;
  logic            gnt_valid_s, wr_s;
  logic [AW-1:0]   wr_addr_s;
  logic [N-1:0]    wr_data_s;
`ifdef REG_BANK_ARB_LOCK_EN
  logic [PW-1:0]   owner_q, owner_d;
  logic            hold_s, lock_next_s;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  // A requester still showing its ACK is skipped, so a held REQ cannot write twice.
  assign elig_s = REQ & ~ack_q;

`ifdef REG_BANK_ARB_LOCK_EN
  // While locked only the owner may write; on release rotation resumes just past it.
  always_comb begin
    if (state_q == LOCKED) begin
      hold_s    = REQ[owner_q] & LOCK[owner_q];
      arb_ptr_s = ptr_inc(owner_q);
    end else begin
      hold_s    = 1'b0;
      arb_ptr_s = ptr_q;
    end
  end
`else
  assign arb_ptr_s = ptr_q;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (elig_s),
    .ptr   (arb_ptr_s),
    .gnt   (gnt_s),
    .valid (gnt_valid_s)
  );

  // Resolve the writer of this cycle and select its address/data slices.
  always_comb begin
    win_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_s = gnt_s[i] ? PW'(i) : win_s;
    end
`ifdef REG_BANK_ARB_LOCK_EN
    win_s       = hold_s ? owner_q : win_s;
    wr_s        = hold_s | gnt_valid_s;
    lock_next_s = wr_s & LOCK[win_s];
`else
    wr_s = gnt_valid_s;
`endif
    wr_addr_s = WADDR[win_s*AW +: AW];
    wr_data_s = WDATA[win_s*N +: N];
  end

  // Next bank contents, ACK pulse, pointer and FSM state.
  always_comb begin
    bank_d  = bank_q;
    ack_d   = '0;
    ptr_d   = arb_ptr_s;
    state_d = IDLE;
`ifdef REG_BANK_ARB_LOCK_EN
    owner_d = owner_q;
`endif
    if (wr_s) begin
      ack_d   = NREQ'(1'b1) << win_s;
      state_d = GRANT;
      ptr_d   = ptr_inc(win_s);
      // Out-of-range writes are acknowledged but leave the bank untouched.
      if ({1'b0, wr_addr_s} < NREG_W) begin
        bank_d[wr_addr_s] = wr_data_s;
      end else begin
        bank_d = bank_q;
      end
`ifdef REG_BANK_ARB_LOCK_EN
      if (lock_next_s) begin
        state_d = LOCKED;
        owner_d = win_s;
        ptr_d   = hold_s ? ptr_q : arb_ptr_s;
      end else begin
        owner_d = owner_q;
      end
`endif
    end else begin
      ack_d   = '0;
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  // State registers; RST clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ack_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        bank_q[r] <= '0;
      end
`ifdef REG_BANK_ARB_LOCK_EN
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
`ifdef REG_BANK_ARB_LOCK_EN
      owner_q <= owner_d;
`endif
    end
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;

  // Combinational read; addresses past the bank read as zero.
  always_comb begin
    if ({1'b0, RADDR} < NREG_W) begin
      RDATA = bank_q[RADDR];
    end else begin
      RDATA = '0;
    end
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: an 8-entry and a 6-entry instance checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_reg_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b, ack_a, ack_b;
  logic [11:0] waddr_a, waddr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [2:0]  raddr_a, raddr_b;
  logic [3:0]  rdata_a, rdata_b;
  logic        busy_a, busy_b;
`ifdef REG_BANK_ARB_LOCK_EN
  logic [3:0]  lock_a, lock_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int rr_seq [5] = '{1, 2, 4, 8, 1};

  // Model state per instance (0: NREG=8, 1: NREG=6).
  int         mbank  [2][8];
  logic [3:0] mack   [2];
  int         mptr   [2];
  bit         mbusy  [2];
  bit         mlocked[2];
  int         mowner [2];

  always #5 clk = ~clk;

  reg_bank_arbiter dut_a (
    .CLK(clk), .RST(rst), .REQ(req_a), .WADDR(waddr_a), .WDATA(wdata_a),
    .ACK(ack_a), .RADDR(raddr_a), .RDATA(rdata_a), .BUSY(busy_a)
`ifdef REG_BANK_ARB_LOCK_EN
    , .LOCK(lock_a)
`endif
  );

  reg_bank_arbiter #(.NREG(6)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req_b), .WADDR(waddr_b), .WDATA(wdata_b),
    .ACK(ack_b), .RADDR(raddr_b), .RDATA(rdata_b), .BUSY(busy_b)
`ifdef REG_BANK_ARB_LOCK_EN
    , .LOCK(lock_b)
`endif
  );

  function automatic int nreg_of(int d);
    return (d == 0) ? 8 : 6;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) mbank[d][a] = 0;
      mack[d] = 4'b0; mptr[d] = 0; mbusy[d] = 1'b0; mlocked[d] = 1'b0; mowner[d] = 0;
    end
  endtask

  // One clock edge of the arbiter, from the rules: pick, write, pulse, rotate.
  task automatic mstep(int d, logic [3:0] req, logic [11:0] wa, logic [15:0] wd, logic [3:0] lk);
    int w = -1;
    int base = mptr[d];
    bit lk_next = 1'b0;
    int a;
    if (mlocked[d] && req[mowner[d]] && lk[mowner[d]]) begin
      w = mowner[d];
      lk_next = 1'b1;
    end else begin
      if (mlocked[d]) base = (mowner[d] + 1) % 4;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (base + k) % 4;
        if (w < 0 && req[idx] && !mack[d][idx]) w = idx;
      end
      if (w >= 0 && lk[w]) lk_next = 1'b1;
    end
    if (w >= 0) begin
      a = int'(wa[w*3 +: 3]);
      if (a < nreg_of(d)) mbank[d][a] = int'(wd[w*4 +: 4]);
      mack[d] = 4'b0001 << w;
    end else begin
      mack[d] = 4'b0000;
    end
    mptr[d]    = (w >= 0 && !lk_next) ? (w + 1) % 4 : base;
    mbusy[d]   = (w >= 0);
    mlocked[d] = lk_next;
    if (lk_next) mowner[d] = w;
  endtask

  // Compare process: outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    logic [3:0] la, lb;
`ifdef REG_BANK_ARB_LOCK_EN
    la = lock_a; lb = lock_b;
`else
    la = 4'b0; lb = 4'b0;
`endif
    if (rst) mreset();
    chk("model_ack_a", ack_a, mack[0]);
    chk("model_busy_a", busy_a, mbusy[0]);
    chk("model_rdata_a", rdata_a, (raddr_a < 8) ? mbank[0][raddr_a] : 0);
    chk("model_ack_b", ack_b, mack[1]);
    chk("model_busy_b", busy_b, mbusy[1]);
    chk("model_rdata_b", rdata_b, (raddr_b < 6) ? mbank[1][raddr_b] : 0);
    if (!rst) begin
      mstep(0, req_a, waddr_a, wdata_a, la);
      mstep(1, req_b, waddr_b, wdata_b, lb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_a = 4'b0; req_b = 4'b0;
    waddr_a = 12'b0; waddr_b = 12'b0; wdata_a = 16'b0; wdata_b = 16'b0;
    raddr_a = 3'd0; raddr_b = 3'd0;
`ifdef REG_BANK_ARB_LOCK_EN
    lock_a = 4'b0; lock_b = 4'b0;
`endif
    step(); step();
    rst = 1'b0;
    step();

    // Round robin: requester i writes i+1 to address i.
    for (int i = 0; i < 4; i++) begin
      waddr_a[i*3 +: 3] = 3'(i);
      wdata_a[i*4 +: 4] = 4'(i + 1);
    end
    raddr_a = 3'd2;
    req_a   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_ack", ack_a, rr_seq[i]);
      if (i >= 2) chk("rr_rdata2", rdata_a, 3);
    end
    step();
    req_a = 4'b0;
    step();

    // Collision on address 4 with the pointer at 2.
    waddr_a = 12'b0; wdata_a = 16'b0;
    waddr_a[3 +: 3] = 3'd4; wdata_a[4 +: 4]  = 4'hA;
    waddr_a[9 +: 3] = 3'd4; wdata_a[12 +: 4] = 4'h5;
    raddr_a = 3'd4;
    req_a   = 4'b1010;
    step();
    chk("col_ack_first", ack_a, 8);
    chk("col_rdata_first", rdata_a, 5);
    req_a = 4'b0010;
    step();
    chk("col_ack_second", ack_a, 2);
    chk("col_rdata_second", rdata_a, 10);
    req_a = 4'b0;
    step(); step();
    chk("col_final", rdata_a, 10);

    // Read timing on address 6.
    waddr_a = 12'b0; wdata_a = 16'b0;
    waddr_a[0 +: 3] = 3'd6; wdata_a[0 +: 4] = 4'h7;
    raddr_a = 3'd6;
    req_a   = 4'b0001;
    #1;
    chk("rt_old", rdata_a, 0);
    step();
    chk("rt_new", rdata_a, 7);
    req_a = 4'b0;
    step();

    // Out-of-range write on the 6-entry bank.
    waddr_b[0 +: 3] = 3'd7; wdata_b[0 +: 4] = 4'hF;
    raddr_b = 3'd7;
    req_b   = 4'b0001;
    step();
    chk("oor_ack", ack_b, 1);
    chk("oor_rdata7", rdata_b, 0);
    req_b = 4'b0;
    for (int k = 0; k < 6; k++) begin
      raddr_b = 3'(k);
      step();
      chk("oor_bank_clean", rdata_b, 0);
    end
    waddr_b[0 +: 3] = 3'd5; wdata_b[0 +: 4] = 4'h9;
    raddr_b = 3'd5;
    req_b   = 4'b0001;
    step();
    chk("top_entry_ack", ack_b, 1);
    chk("top_entry_rdata", rdata_b, 9);
    req_b = 4'b0;
    step();

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) begin
      waddr_a[i*3 +: 3] = 3'(i + 4);
      wdata_a[i*4 +: 4] = 4'(12 + i);
    end
    req_a = 4'b1111;
    step();
    chk("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_busy", busy_a, 0);
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      step();
      chk("rst_rdata", rdata_a, 0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_first", ack_a, 1);
    req_a = 4'b0;
    step();

`ifdef REG_BANK_ARB_LOCK_EN
    // Bring the pointer to 0, then a three-cycle locked burst from requester 0.
    req_a = 4'b1000;
    step();
    req_a = 4'b0;
    step();
    waddr_a = 12'b0; wdata_a = 16'b0;
    waddr_a[0 +: 3] = 3'd0; wdata_a[0 +: 4] = 4'hD;
    waddr_a[3 +: 3] = 3'd1; wdata_a[4 +: 4] = 4'hE;
    req_a  = 4'b0011;
    lock_a = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_ack", ack_a, 1);
      chk("lock_busy", busy_a, 1);
    end
    lock_a = 4'b0;
    step();
    chk("lock_release_ack", ack_a, 2);
    req_a = 4'b0;
    step();
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, register data width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of write requesters.
REQ-003 The block SHALL have parameter NREG, default 8, number of registers in the bank; AW = $clog2(NREG).
REQ-004 The block SHALL have port CLK, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port REQ, input, NREQ bits, write request per requester; requester i owns bit i.
REQ-007 The block SHALL have port WADDR, input, NREQ*AW bits, flattened write addresses; slice i belongs to requester i.
REQ-008 The block SHALL have port WDATA, input, NREQ*N bits, flattened write data; slice i belongs to requester i.
REQ-009 The block SHALL have port ACK, output, NREQ bits, registered one-cycle write-done pulse per requester.
REQ-010 The block SHALL have port RADDR, input, AW bits, read address.
REQ-011 The block SHALL have port RDATA, output, N bits, read data.
REQ-012 The block SHALL have port BUSY, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 Each cycle, at most one requester SHALL win; the winner is chosen round-robin starting at pointer PTR, using active bits of REQ & ~ACK.
REQ-014 On the edge closing a cycle with a winner w: bank[WADDR_w] <= WDATA_w; ACK <= one-hot(w); PTR <= (w+1) mod NREQ.
REQ-015 Write latency SHALL be one edge; ACK[w] is high exactly during the cycle after the write.
REQ-016 A requester whose ACK bit is high SHALL be excluded from arbitration that cycle, so a held REQ never double-writes.
REQ-017 With no eligible request, ACK SHALL be all-zero next cycle and PTR SHALL hold.
REQ-018 RDATA SHALL be combinational bank[RADDR]; a write reaches RDATA only in the cycle after its edge.
REQ-019 A write to an address >= NREG SHALL be dropped but still acknowledged; a read from such an address SHALL return 0.
REQ-020 When several requesters target the same address in one cycle, only the winner SHALL write; losers stay pending.
REQ-021 The FSM SHALL have states IDLE (no winner last cycle), GRANT (write performed last cycle) and LOCKED (see REQ-026); transitions are IDLE/GRANT -> GRANT on a winner, otherwise -> IDLE.
REQ-022 PTR SHALL wrap from NREQ-1 to 0.

Reset
REQ-023 While RST is high: bank entries = 0, ACK = 0, PTR = 0, state = IDLE, BUSY = 0, regardless of CLK.
REQ-024 Assertion of RST during a pending request SHALL discard it; no ACK is issued for it after release.
REQ-025 The first winner after RST release SHALL be the lowest-index requester asserting REQ.

Configuration
REQ-026 With macro REG_BANK_ARB_LOCK_EN defined, the block SHALL add input LOCK (NREQ bits). A winner with LOCK[w]=1 moves the FSM to LOCKED. In LOCKED, only w is eligible: with REQ[w] high it writes every cycle, ignoring REQ-016. State returns to GRANT or IDLE per REQ-021 on the first cycle with LOCK[w]=0 or REQ[w]=0. PTR is updated only on leaving LOCKED.
REQ-027 Without REG_BANK_ARB_LOCK_EN, the LOCK port and the LOCKED state SHALL not exist, and the behaviour SHALL be REQ-013..022 only.

Structure
REQ-028 Package reg_bank_arb_pkg SHALL hold the state enum type (IDLE, GRANT, LOCKED) and the default values of N, NREQ and NREG.
REQ-029 The rotating-priority pick SHALL be sub-module rr_arbiter (inputs: request vector, PTR; outputs: one-hot grant, valid); the bank and FSM SHALL stay in reg_bank_arbiter.

Verification
REQ-030 Reset test: RST high mid-run with REQ=4'b1111 -> ACK=0, BUSY=0, RDATA=0 for all RADDR 0..7; the first grant after release goes to requester 0.
REQ-031 Round-robin test: REQ=4'b1111 held, each requester targets addr i with data i+1 -> ACK sequence 0001,0010,0100,1000,0001 with no repeats; RADDR=2 reads 3.
REQ-032 Collision test: req1 writes 0xA and req3 writes 0x5 to addr 4 in the same cycle, PTR=2 -> req3 wins first and req1 wins next, final bank[4]=0xA.
REQ-033 Read-timing test: write 0x7 to addr 6 with RADDR=6 -> RDATA shows the old value 0 in the write cycle and 0x7 the cycle after.
REQ-034 Out-of-range test (NREG=6): write 0xF to addr 7 -> ACK pulses, no bank entry changes, and RADDR=7 reads 0.
REQ-035 Lock test (REG_BANK_ARB_LOCK_EN): req0 writes with LOCK[0]=1 for 3 cycles while REQ=4'b0011 -> three consecutive req0 writes, BUSY=1; after LOCK drops, req1 gets the next grant.
